// File: rtl/aes_pkg.sv
// aes_pkg: AES key-size encodings, round counts, inverse-round FSM states and GF(2^8) multiply helpers
package aes_pkg;
  localparam logic [1:0] MODE_128 = 2'b00, MODE_192 = 2'b01, MODE_256 = 2'b10;
  localparam logic [3:0] NR_128 = 4'd10, NR_192 = 4'd12, NR_256 = 4'd14;
  typedef enum logic [2:0] {IDLE, ARK0, SUB, MIX, DONE} state_e;
  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    return (mode & MODE_256) != 2'b00 ? NR_256 : mode == MODE_192 ? NR_192 : NR_128;
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction
  function automatic logic [7:0] gm11(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction
  function automatic logic [7:0] gm13(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction
  function automatic logic [7:0] gm14(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm9(a3),
            gm9(a0) ^ gm14(a1) ^ gm11(a2) ^ gm13(a3),
            gm13(a0) ^ gm9(a1) ^ gm14(a2) ^ gm11(a3),
            gm11(a0) ^ gm13(a1) ^ gm9(a2) ^ gm14(a3)};
  endfunction
endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: combinational AES inverse S-box, a (8b) -> y (8b)
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [7:0] lut [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
  assign y = lut[a];
endmodule

// File: rtl/aes_inv_rounddata.sv
// aes_inv_rounddata: one AES inverse step (clk, reset, start, round, mode, round_key, data_in -> busy, done, data_out); S-box result is registered so SUB drains one extra cycle; define AES_INV_MIXCOL_PAR_EN for single-cycle InvMixColumns
module aes_inv_rounddata
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   round,
  input  logic [1:0]   mode,
  input  logic [127:0] round_key,
  input  logic [127:0] data_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d, wr_idx_q, wr_idx_d;
  logic pend_q, pend_d;
  logic [7:0] sb_q, sb_d, sb_in, sb_out;
  logic [127:0] work_q, work_d, out_q, out_d, isr;
  for (genvar k = 0; k < 16; k++) begin : g_isr
    localparam int s = 4 * ((k / 4 - k % 4 + 4) % 4) + k % 4;
    assign isr[127-8*k -: 8] = data_in[127-8*s -: 8];
  end
  assign sb_in = isr[8*(15-cnt_q) +: 8];
  aes_inv_sbox u_sbox (.a(sb_in), .y(sb_out));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_idx_d = cnt_q;
    pend_d = 1'b0;
    sb_d = sb_out ^ round_key[8*(15-cnt_q) +: 8];
    work_d = work_q;
    out_d = out_q;
    case (state_q)
      IDLE: begin
        state_d = start ? (round == 4'd0 ? ARK0 : SUB) : IDLE;
        cnt_d = start ? 4'd0 : cnt_q;
      end
      ARK0: begin
        work_d = data_in ^ round_key;
        state_d = DONE;
      end
      SUB: begin
        pend_d = 1'b1;
        cnt_d = cnt_q == 4'd15 ? cnt_q : cnt_q + 4'd1;
        if (pend_q) work_d[8*(15-wr_idx_q) +: 8] = sb_q;
        if (pend_q && wr_idx_q == 4'd15) begin
          state_d = round == nr_of(mode) ? DONE : MIX;
          cnt_d = 4'd0;
          pend_d = 1'b0;
        end
      end
`ifdef AES_INV_MIXCOL_PAR_EN
      MIX: begin
        for (int c = 0; c < 4; c++) work_d[32*(3-c) +: 32] = inv_mix_col(work_q[32*(3-c) +: 32]);
        state_d = DONE;
      end
`else
      MIX: begin
        work_d[32*(3-cnt_q[1:0]) +: 32] = inv_mix_col(work_q[32*(3-cnt_q[1:0]) +: 32]);
        cnt_d = cnt_q + 4'd1;
        state_d = cnt_q == 4'd3 ? DONE : MIX;
      end
`endif
      DONE: begin
        out_d = work_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_idx_q <= '0;
      pend_q <= 1'b0;
      sb_q <= '0;
      work_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_idx_q <= wr_idx_d;
      pend_q <= pend_d;
      sb_q <= sb_d;
      work_q <= work_d;
      out_q <= out_d;
    end
  end
  assign busy = state_q == ARK0 || state_q == SUB || state_q == MIX;
  assign done = state_q == DONE;
  assign data_out = done ? work_q : out_q;
endmodule
